alu_muldiv_ctrl: RTL and testbench
==================================

Name: alu_muldiv_ctrl

Overview:
- Next-generation ALU controller: same ALUOp/Funct3/Funct7 decode to the 4-bit ALU Operation code, plus the RV32M extension (Funct7=0000001).
- Adds an iterative multiply/divide sequencer for M ops with a start/busy/done handshake.
- Sits between the main Controller/datapath and the ALU; the datapath stalls on busy.

Parameters:
- XLEN, 32, operand/result width (>=8, even).
- MUL_EN, 1, 1 = MUL/MULH/MULHSU/MULHU supported.
- DIV_EN, 1, 1 = DIV/DIVU/REM/REMU supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ALUOp  in  2  00 LW/SW/JALR, 01 branch, 10 R/I-type, 11 JAL/LUI.
- Funct7  in  7  instr[31:25].
- Funct3  in  3  instr[14:12].
- start  in  1  issue strobe for the current instruction.
- kill  in  1  pipeline flush; aborts any M op in flight.
- SrcA  in  XLEN  rs1 operand.
- SrcB  in  XLEN  rs2 operand.
- Operation  out  4  ALU op select (combinational).
- md_op  out  1  current decode is an enabled M op (combinational).
- illegal  out  1  M op with its unit disabled (combinational).
- busy  out  1  sequencer running; datapath must stall.
- done  out  1  one-cycle pulse; md_result valid.
- md_result  out  XLEN  M-op result, held until next accepted start.

Behaviour:
- Operation encoding: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, BEQ 1000, BNE 1001, SLT/BLT/JAL/LUI 1010, BGE 1011.
- ALUOp 00 -> ADD. ALUOp 11 -> 1010. ALUOp 01 by Funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
- ALUOp 10 with Funct7 != 0000001, by Funct3: 000 ADD, or SUB if Funct7=0100000. 001 SLL. 010 SLT. 100 XOR. 101 SRL, or SRA if Funct7=0100000. 110 OR. 111 AND.
- ALUOp 10 with Funct7=0000001: md_op=1 and Operation=0010. Funct3 selects 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- illegal=1 when the Funct3 class is disabled (Funct3[2]=0 needs MUL_EN, Funct3[2]=1 needs DIV_EN). md_op=0 whenever illegal=1.
- Reset (async, rst_n low): state IDLE; busy=0; done=0; md_result=0; internal accumulator, operands and counter cleared.
- FSM states: IDLE, CALC, FIN.
- IDLE: start=1 and md_op=1 and kill=0 -> latch operands, magnitudes, result-sign and op.
  - Special case, divisor==0: quotient all-ones, remainder = SrcA.
  - Special case, signed DIV/REM with SrcA=MIN and SrcB=-1: quotient MIN, remainder 0.
  - Special case -> FIN. Otherwise load counter = XLEN-1 -> CALC.
- CALC: busy=1. One radix-2 step per cycle.
  - Multiply: shift-add on unsigned magnitudes into a 2*XLEN accumulator.
  - Divide: restoring divide on magnitudes.
  - Counter reaching 0 -> FIN.
- FIN: busy=1. Apply sign correction and select the result.
  - MUL: low half. MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient. REM/REMU: remainder; remainder sign follows dividend.
  - Register md_result; done=1 on the next cycle; -> IDLE.
- Latency, start at edge 0:
  - Normal op: busy high edges 1..XLEN+1; done high at edge XLEN+2.
  - Special-case divide: busy high at edge 1 only; done high at edge 2.
- MULHSU: SrcA signed, SrcB unsigned.
- start while busy=1 is ignored. start with md_op=0 is ignored by the sequencer; the base op completes in the ALU in zero cycles.
- kill in CALC or FIN -> IDLE next edge. done is not asserted and md_result keeps its old value. kill has priority over start in the same cycle.
- done and start in the same cycle: a new op is accepted in IDLE (back-to-back allowed).

Decomposition:
- Shared package alu_pkg:
  - Operation encoding constants (OP_AND..OP_BGE).
  - ALUOp constants.
  - Funct7 constants: F7_BASE 0000000, F7_ALT 0100000, F7_MULDIV 0000001.
  - M-op Funct3 enum.
  - FSM state typedef.
- One sub-module, muldiv_core: holds the datapath (accumulator, iterative step, sign fix). This block keeps the decode and FSM.

Test Plan:
- Base decode sweep: ALUOp=10, Funct3=101, Funct7=0100000 -> Operation=0111, md_op=0. ALUOp=01, Funct3=101 -> 1011. ALUOp=11 -> 1010.
- MUL: SrcA=-3, SrcB=7, Funct3=000 -> done at cycle 34 (XLEN=32), md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV/REM signed: -7/2 -> quotient 0xFFFFFFFD. REM -> 0xFFFFFFFF.
- Special cases: DIVU 5/0 -> 0xFFFFFFFF with done at cycle 2. REM 5/0 -> 5. DIV 0x80000000 / -1 -> 0x80000000 at cycle 2.
- kill at cycle 10 of a DIV -> busy low at cycle 11, no done, md_result unchanged. A new start at cycle 12 is accepted.
- rst_n pulsed low mid-CALC (asynchronous, between edges) -> busy/done/md_result = 0 immediately. MUL_EN=0 build with MUL decode -> illegal=1, start ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: operation codes, decode constants, M-op and FSM types.
package alu_pkg;

    // ALU operation select codes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_SLT = 4'b1010;  // also BLT, JAL, LUI
    localparam logic [3:0] OP_BGE = 4'b1011;

    // ALUOp classes from the main controller
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_JUMP   = 2'b11;

    // Funct7 patterns
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // RV32M Funct3 selection
    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } md_funct_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide datapath: operand prep, radix-2 step, sign fix-up.
module muldiv_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_fin,
    input  logic [2:0]      i_funct,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_special,
    output logic [XLEN-1:0] o_result
);

    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    // Accumulator: multiply = {partial high, multiplier}; divide = {remainder, quotient}
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;     // multiplicand or divisor magnitude
    md_funct_e         r_funct;
    logic              r_neg;      // product / quotient must be negated
    logic              r_neg_rem;  // remainder must be negated (follows dividend)
    logic [XLEN-1:0]   r_result;

    logic              w_is_div;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_step_acc;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    // Operand signedness, magnitudes and divide special-case detection
    always_comb begin
        w_is_div   = i_funct[2];
        w_a_sgn    = i_src_a[XLEN-1] & (w_is_div ? ~i_funct[0] : (i_funct[1:0] != 2'b11));
        w_b_sgn    = i_src_b[XLEN-1] & (w_is_div ? ~i_funct[0] : ~i_funct[1]);
        w_mag_a    = w_a_sgn ? -i_src_a : i_src_a;
        w_mag_b    = w_b_sgn ? -i_src_b : i_src_b;
        w_div_zero = (i_src_b == {XLEN{1'b0}});
        w_div_ovf  = ~i_funct[0] & (i_src_a == MIN_V) & (i_src_b == {XLEN{1'b1}});
        o_special  = w_is_div & (w_div_zero | w_div_ovf);
    end

    // One shift-add (multiply) or restoring-subtract (divide) iteration
    always_comb begin
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_opnd};
        if (r_funct[2]) begin
            if (!w_diff[XLEN]) begin
                w_step_acc = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_step_acc = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            w_step_acc = {w_sum, r_acc[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    always_comb begin
        w_prod = r_neg ? -r_acc : r_acc;
        w_quot = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        case (r_funct)
            M_MUL:                      w_result = w_prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU:  w_result = w_prod[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:              w_result = w_quot;
            M_REM, M_REMU:              w_result = w_rem;
            default:                    w_result = w_quot;
        endcase
    end

    // Datapath registers: load operands, iterate, capture result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= {(2*XLEN){1'b0}};
            r_opnd    <= {XLEN{1'b0}};
            r_funct   <= M_MUL;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= {XLEN{1'b0}};
        end else if (i_load) begin
            r_funct <= md_funct_e'(i_funct);
            if (o_special) begin
                // Final {remainder, quotient} preloaded; no sign fix needed
                r_acc     <= w_div_zero ? {i_src_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN_V};
                r_opnd    <= {XLEN{1'b0}};
                r_neg     <= 1'b0;
                r_neg_rem <= 1'b0;
            end else if (w_is_div) begin
                r_acc     <= {{XLEN{1'b0}}, w_mag_a};
                r_opnd    <= w_mag_b;
                r_neg     <= w_a_sgn ^ w_b_sgn;
                r_neg_rem <= w_a_sgn;
            end else begin
                r_acc     <= {{XLEN{1'b0}}, w_mag_b};
                r_opnd    <= w_mag_a;
                r_neg     <= w_a_sgn ^ w_b_sgn;
                r_neg_rem <= 1'b0;
            end
        end else if (i_step) begin
            r_acc <= w_step_acc;
        end else if (i_fin) begin
            r_result <= w_result;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// ALU controller: base/RV32M decode plus the multiply/divide sequencer FSM.
module alu_muldiv_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1,
    parameter int DIV_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [3:0]      Operation,
    output logic            md_op,
    output logic            illegal,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] md_result
);

    localparam int   CNT_W  = $clog2(XLEN);
    localparam logic MUL_OK = (MUL_EN != 0);
    localparam logic DIV_OK = (DIV_EN != 0);

    md_state_e        r_state;
    md_state_e        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             w_load;
    logic             w_step;
    logic             w_fin;
    logic             w_special;

    // Instruction decode to ALU operation, M-op flag and illegal flag
    always_comb begin
        Operation = OP_ADD;
        md_op     = 1'b0;
        illegal   = 1'b0;
        case (ALUOp)
            ALUOP_MEM:    Operation = OP_ADD;
            ALUOP_BRANCH: begin
                case (Funct3)
                    3'b000:  Operation = OP_BEQ;
                    3'b001:  Operation = OP_BNE;
                    3'b100:  Operation = OP_SLT;
                    3'b101:  Operation = OP_BGE;
                    default: Operation = OP_ADD;
                endcase
            end
            ALUOP_RTYPE: begin
                if (Funct7 == F7_MULDIV) begin
                    Operation = OP_ADD;
                    if (Funct3[2] ? DIV_OK : MUL_OK) begin
                        md_op = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    case (Funct3)
                        3'b000:  Operation = (Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                        3'b001:  Operation = OP_SLL;
                        3'b010:  Operation = OP_SLT;
                        3'b100:  Operation = OP_XOR;
                        3'b101:  Operation = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                        3'b110:  Operation = OP_OR;
                        3'b111:  Operation = OP_AND;
                        default: Operation = OP_ADD;
                    endcase
                end
            end
            ALUOP_JUMP:   Operation = OP_SLT;
            default:      Operation = OP_ADD;
        endcase
    end

    // Sequencer next state and datapath strobes; kill wins over everything
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && md_op && !kill) begin
                    w_load = 1'b1;
                    w_next = w_special ? ST_FIN : ST_CALC;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    w_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    w_next = (r_cnt == {CNT_W{1'b0}}) ? ST_FIN : ST_CALC;
                end
            end
            ST_FIN: begin
                if (kill) begin
                    w_next = ST_IDLE;
                end else begin
                    w_fin  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, iteration counter and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fin;
            if (w_load) begin
                r_cnt <= CNT_W'(XLEN-1);
            end else if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_fin     (w_fin),
        .i_funct   (Funct3),
        .i_src_a   (SrcA),
        .i_src_b   (SrcB),
        .o_special (w_special),
        .o_result  (md_result)
    );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: directed decode/latency cases plus random M ops.
module tb_alu_muldiv_ctrl;

    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic        start;
    logic        kill;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        md_op, illegal, busy, done;
    logic [31:0] md_result;
    logic [3:0]  nm_Operation;
    logic        nm_md_op, nm_illegal, nm_busy, nm_done;
    logic [31:0] nm_md_result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_muldiv_ctrl #(.XLEN(XLEN), .MUL_EN(1), .DIV_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .start(start), .kill(kill), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .md_op(md_op), .illegal(illegal),
        .busy(busy), .done(done), .md_result(md_result)
    );

    // Build without the multiplier: MUL decodes must be flagged and ignored
    alu_muldiv_ctrl #(.XLEN(XLEN), .MUL_EN(0), .DIV_EN(1)) dut_nm (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .start(start), .kill(kill), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(nm_Operation), .md_op(nm_md_op), .illegal(nm_illegal),
        .busy(nm_busy), .done(nm_done), .md_result(nm_md_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        ALUOp  = 2'b10;
        Funct7 = 7'b0000001;
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
    endtask

    // Issue one M op; lat = edges after the issuing edge until done is visible
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        set_m(f, a, b);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        res = md_result;
    endtask

    // Reference RV32M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            3'd7: return (b == 32'h0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'h0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF));
    endfunction

    initial begin
        int          lat;
        logic [31:0] res;
        logic [2:0]  f;
        logic [31:0] a, b;

        rst_n = 1'b0; start = 1'b0; kill = 1'b0;
        ALUOp = 2'b00; Funct7 = 7'h0; Funct3 = 3'h0; SrcA = 32'h0; SrcB = 32'h0;

        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(md_result), 64'd0);
        rst_n = 1'b1;
        tick();

        // Base decode
        ALUOp = 2'b10; Funct3 = 3'b101; Funct7 = 7'b0100000; #1;
        check("dec_sra", 64'(Operation), 64'b0111);
        check("dec_sra_mdop", 64'(md_op), 64'd0);
        ALUOp = 2'b01; Funct3 = 3'b101; Funct7 = 7'b0; #1;
        check("dec_bge", 64'(Operation), 64'b1011);
        Funct3 = 3'b001; #1;
        check("dec_bne", 64'(Operation), 64'b1001);
        ALUOp = 2'b11; #1;
        check("dec_jal", 64'(Operation), 64'b1010);
        ALUOp = 2'b00; #1;
        check("dec_lw", 64'(Operation), 64'b0010);
        ALUOp = 2'b10; Funct3 = 3'b000; Funct7 = 7'b0100000; #1;
        check("dec_sub", 64'(Operation), 64'b0011);
        Funct3 = 3'b010; Funct7 = 7'b0; #1;
        check("dec_slt", 64'(Operation), 64'b1010);

        // M decode in both builds
        set_m(3'b000, -32'sd3, 32'd7); #1;
        check("dec_mul_op", 64'(Operation), 64'b0010);
        check("dec_mul_mdop", 64'(md_op), 64'd1);
        check("dec_mul_illegal", 64'(illegal), 64'd0);
        check("nm_mul_illegal", 64'(nm_illegal), 64'd1);
        check("nm_mul_mdop", 64'(nm_md_op), 64'd0);

        // MUL -3 * 7: done seen after edge XLEN+1 (sampled at edge XLEN+2)
        run_op(3'b000, -32'sd3, 32'd7, lat, res);
        check("mul_latency", 64'(lat), 64'(XLEN + 1));
        check("mul_result", 64'(res), 64'hFFFF_FFEB);
        check("nm_mul_ignored", 64'(nm_md_result), 64'd0);
        check("nm_mul_busy", 64'(nm_busy), 64'd0);

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        check("mulhu_result", 64'(res), 64'hFFFF_FFFE);

        run_op(3'b100, -32'sd7, 32'd2, lat, res);
        check("div_neg_result", 64'(res), 64'hFFFF_FFFD);
        run_op(3'b110, -32'sd7, 32'd2, lat, res);
        check("rem_neg_result", 64'(res), 64'hFFFF_FFFF);

        // Special cases finish in FIN directly
        run_op(3'b101, 32'd5, 32'd0, lat, res);
        check("divu0_latency", 64'(lat), 64'd1);
        check("divu0_result", 64'(res), 64'hFFFF_FFFF);
        run_op(3'b110, 32'd5, 32'd0, lat, res);
        check("rem0_result", 64'(res), 64'd5);
        run_op(3'b100, MINV, 32'hFFFF_FFFF, lat, res);
        check("divovf_latency", 64'(lat), 64'd1);
        check("divovf_result", 64'(res), 64'(MINV));

        // Kill sampled at edge 10 of a DIV; restart accepted at edge 12
        set_m(3'b100, 32'd1000, 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_done", 64'(done), 64'd0);
        check("kill_result_held", 64'(md_result), 64'(MINV));
        tick();
        check("kill_no_done", 64'(done), 64'd0);
        run_op(3'b100, 32'd1000, 32'd3, lat, res);
        check("restart_latency", 64'(lat), 64'(XLEN + 1));
        check("restart_result", 64'(res), 64'd333);

        // Random back-to-back M ops against the reference
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       begin a = MINV; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       a = -32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(f, a, b, lat, res);
            check("rand_latency", 64'(lat), is_special(f, a, b) ? 64'd1 : 64'(XLEN + 1));
            check("rand_result", 64'(res), 64'(ref_md(f, a, b)));
        end

        // Asynchronous reset between edges during CALC
        run_op(3'b101, 32'd100, 32'd7, lat, res);
        check("pre_reset_result", 64'(res), 64'd14);
        set_m(3'b000, 32'd9, 32'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", 64'(md_result), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
